// File: rtl/uart_crc_link_param.sv
// uart_crc_link_param
// Serial link with a UART transmitter and receiver. Each frame carries a
// DATA_W-bit payload (LSB first) followed by a CRC_W-bit CRC (MSB first).
// The receiver recomputes the CRC over the payload and flags whether the
// received CRC matched. A frame whose stop bit is sampled low is reported as
// a framing error. With LOOPBACK=1 the receiver listens to this block's own
// transmitter, so it can be brought up with no external wiring.
module uart_crc_link_param #(
    parameter int               DATA_W       = 8,
    parameter int               CRC_W        = 8,
    parameter logic [CRC_W-1:0] CRC_POLY     = CRC_W'(8'h07),
    parameter logic [CRC_W-1:0] CRC_INIT     = '0,
    parameter int               CLKS_PER_BIT = 16,
    parameter bit               LOOPBACK     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data_in,
    input  logic              tx_start,
    input  logic              err_inj,
    input  logic              rx_serial_in,
    output logic              tx_serial_out,
    output logic              tx_busy_out,
    output logic [DATA_W-1:0] rx_data_out,
    output logic              rx_ready_out,
    output logic              crc_valid_out,
    output logic              frame_err_out
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int MAX_W = (DATA_W > CRC_W) ? DATA_W : CRC_W;
    localparam int IDX_W = $clog2(MAX_W);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] CRC_LAST  = IDX_W'(CRC_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_CRC,
        ST_STOP
    } state_t;

    // Bitwise MSB-first CRC, payload walked from its top bit down to bit 0.
    function automatic logic [CRC_W-1:0] crc_calc(input logic [DATA_W-1:0] data);
        logic [CRC_W-1:0] crc;
        logic             fb;
        crc = CRC_INIT;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb  = crc[CRC_W-1] ^ data[i];
            crc = {crc[CRC_W-2:0], 1'b0};
            if (fb) begin
                crc = crc ^ CRC_POLY;
            end
        end
        return crc;
    endfunction

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t            tx_state;
    logic [CNT_W-1:0]  tx_cnt;
    logic [IDX_W-1:0]  tx_idx;
    logic [DATA_W-1:0] tx_data_sr;
    logic [CRC_W-1:0]  tx_crc_sr;
    logic              tx_inj;
    logic [CRC_W-1:0]  tx_crc_new;
    logic [DATA_W-1:0] tx_data_shift;
    logic [CRC_W-1:0]  tx_crc_shift;

    // The CRC covers the original payload; injection only touches the line.
    assign tx_crc_new    = crc_calc(tx_data_in);
    assign tx_data_shift = tx_data_sr >> 1;
    assign tx_crc_shift  = tx_crc_sr << 1;

    // TX FSM: the line value for each bit is registered at the bit boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state      <= ST_IDLE;
            tx_cnt        <= '0;
            tx_idx        <= '0;
            tx_data_sr    <= '0;
            tx_crc_sr     <= '0;
            tx_inj        <= 1'b0;
            tx_serial_out <= 1'b1;
            tx_busy_out   <= 1'b0;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (tx_start) begin
                        tx_data_sr    <= tx_data_in;
                        tx_crc_sr     <= tx_crc_new;
                        tx_inj        <= err_inj;
                        tx_serial_out <= 1'b0;
                        tx_busy_out   <= 1'b1;
                        tx_cnt        <= '0;
                        tx_idx        <= '0;
                        tx_state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt        <= '0;
                        tx_serial_out <= tx_data_sr[0] ^ tx_inj;
                        tx_state      <= ST_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt     <= '0;
                        tx_data_sr <= tx_data_shift;
                        if (tx_idx == DATA_LAST) begin
                            tx_idx        <= '0;
                            tx_serial_out <= tx_crc_sr[CRC_W-1];
                            tx_state      <= ST_CRC;
                        end else begin
                            tx_idx        <= tx_idx + 1'b1;
                            tx_serial_out <= tx_data_shift[0];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                ST_CRC: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == CRC_LAST) begin
                            tx_idx        <= '0;
                            tx_serial_out <= 1'b1;
                            tx_state      <= ST_STOP;
                        end else begin
                            tx_idx        <= tx_idx + 1'b1;
                            tx_crc_sr     <= tx_crc_shift;
                            tx_serial_out <= tx_crc_shift[CRC_W-1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt      <= '0;
                        tx_busy_out <= 1'b0;
                        tx_state    <= ST_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic              rx_line;
    logic              rx_sync1;
    logic              rx_sync2;
    state_t            rx_state;
    logic [CNT_W-1:0]  rx_cnt;
    logic [IDX_W-1:0]  rx_idx;
    logic [DATA_W-1:0] rx_data_sr;
    logic [CRC_W-1:0]  rx_crc_sr;
    logic              rx_done;
    logic              rx_stop_bit;
    logic [DATA_W-1:0] rx_data_ins;
    logic [CRC_W-1:0]  rx_crc_calc;

    assign rx_line     = LOOPBACK ? tx_serial_out : rx_serial_in;
    assign rx_crc_calc = crc_calc(rx_data_sr);

    // Payload arrives LSB first, so each new bit enters at the top.
    always_comb begin
        rx_data_ins             = rx_data_sr >> 1;
        rx_data_ins[DATA_W-1]   = rx_sync2;
    end

    // Two-flop synchroniser; resets high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
        end else begin
            rx_sync1 <= rx_line;
            rx_sync2 <= rx_sync1;
        end
    end

    // RX FSM: half-bit wait to mid-start, then one sample per bit period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state    <= ST_IDLE;
            rx_cnt      <= '0;
            rx_idx      <= '0;
            rx_data_sr  <= '0;
            rx_crc_sr   <= '0;
            rx_done     <= 1'b0;
            rx_stop_bit <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (rx_state)
                ST_IDLE: begin
                    if (!rx_sync2) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_idx <= '0;
                        if (rx_sync2) begin
                            rx_state <= ST_IDLE;
                        end else begin
                            rx_state <= ST_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt     <= '0;
                        rx_data_sr <= rx_data_ins;
                        if (rx_idx == DATA_LAST) begin
                            rx_idx   <= '0;
                            rx_state <= ST_CRC;
                        end else begin
                            rx_idx <= rx_idx + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                ST_CRC: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt    <= '0;
                        rx_crc_sr <= {rx_crc_sr[CRC_W-2:0], rx_sync2};
                        if (rx_idx == CRC_LAST) begin
                            rx_idx   <= '0;
                            rx_state <= ST_STOP;
                        end else begin
                            rx_idx <= rx_idx + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt      <= '0;
                        rx_done     <= 1'b1;
                        rx_stop_bit <= rx_sync2;
                        rx_state    <= ST_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    rx_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Frame result is published the cycle after the stop sample, letting RX hunt the next start meanwhile.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data_out   <= '0;
            rx_ready_out  <= 1'b0;
            crc_valid_out <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            rx_ready_out  <= 1'b0;
            frame_err_out <= 1'b0;
            if (rx_done) begin
                if (rx_stop_bit) begin
                    rx_data_out   <= rx_data_sr;
                    crc_valid_out <= (rx_crc_sr == rx_crc_calc);
                    rx_ready_out  <= 1'b1;
                end else begin
                    crc_valid_out <= 1'b0;
                    frame_err_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_crc_link_param.sv
// tb_uart_crc_link_param
// Three instances: default loopback link, default link fed from an external
// line driven by the bench, and a 16/16-bit loopback link.
module tb_uart_crc_link_param;

    localparam int CPB    = 16;
    localparam int DW     = 8;
    localparam int CW     = 8;
    localparam int WDW    = 16;
    localparam int WCW    = 16;
    localparam int LAT    = (DW + CW + 1) * CPB + CPB / 2 + 4;
    localparam int FRAME  = (DW + CW + 2) * CPB;
    localparam int WLAT   = (WDW + WCW + 1) * CPB + CPB / 2 + 4;
    localparam int WFRAME = (WDW + WCW + 2) * CPB;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    // Edge counter read only on falling edges, so it is always stable there.
    always @(posedge clk) cyc++;

    // Loopback instance signals
    logic [7:0] lb_data;
    logic       lb_start;
    logic       lb_inj;
    logic       lb_idle_line;
    logic       lb_tx;
    logic       lb_busy;
    logic [7:0] lb_rx_data;
    logic       lb_ready;
    logic       lb_valid;
    logic       lb_ferr;

    // External-line instance signals
    logic [7:0] ex_data;
    logic       ex_start;
    logic       ex_inj;
    logic       ex_line;
    logic       ex_tx;
    logic       ex_busy;
    logic [7:0] ex_rx_data;
    logic       ex_ready;
    logic       ex_valid;
    logic       ex_ferr;

    // Wide instance signals
    logic [15:0] wd_data;
    logic        wd_start;
    logic        wd_inj;
    logic        wd_idle_line;
    logic        wd_tx;
    logic        wd_busy;
    logic [15:0] wd_rx_data;
    logic        wd_ready;
    logic        wd_valid;
    logic        wd_ferr;

    uart_crc_link_param #(
        .DATA_W(DW), .CRC_W(CW), .CRC_POLY(8'h07), .CRC_INIT(8'h00),
        .CLKS_PER_BIT(CPB), .LOOPBACK(1'b1)
    ) u_lb (
        .clk(clk), .reset(rst_n), .tx_data_in(lb_data), .tx_start(lb_start),
        .err_inj(lb_inj), .rx_serial_in(lb_idle_line), .tx_serial_out(lb_tx),
        .tx_busy_out(lb_busy), .rx_data_out(lb_rx_data), .rx_ready_out(lb_ready),
        .crc_valid_out(lb_valid), .frame_err_out(lb_ferr)
    );

    uart_crc_link_param #(
        .DATA_W(DW), .CRC_W(CW), .CRC_POLY(8'h07), .CRC_INIT(8'h00),
        .CLKS_PER_BIT(CPB), .LOOPBACK(1'b0)
    ) u_ex (
        .clk(clk), .reset(rst_n), .tx_data_in(ex_data), .tx_start(ex_start),
        .err_inj(ex_inj), .rx_serial_in(ex_line), .tx_serial_out(ex_tx),
        .tx_busy_out(ex_busy), .rx_data_out(ex_rx_data), .rx_ready_out(ex_ready),
        .crc_valid_out(ex_valid), .frame_err_out(ex_ferr)
    );

    uart_crc_link_param #(
        .DATA_W(WDW), .CRC_W(WCW), .CRC_POLY(16'h1021), .CRC_INIT(16'hFFFF),
        .CLKS_PER_BIT(CPB), .LOOPBACK(1'b1)
    ) u_wd (
        .clk(clk), .reset(rst_n), .tx_data_in(wd_data), .tx_start(wd_start),
        .err_inj(wd_inj), .rx_serial_in(wd_idle_line), .tx_serial_out(wd_tx),
        .tx_busy_out(wd_busy), .rx_data_out(wd_rx_data), .rx_ready_out(wd_ready),
        .crc_valid_out(wd_valid), .frame_err_out(wd_ferr)
    );

    typedef struct {
        logic [7:0] data;
        logic       inj;
        logic [7:0] line_crc;
        logic [7:0] rx_data;
        logic       valid;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       valid;
        int         start_cyc;
    } exp_t;

    vec_t vecs[5];
    exp_t sb_q[$];
    int   lb_ready_cnt = 0;
    int   ex_ready_cnt = 0;
    int   ex_ferr_cnt  = 0;
    int   wd_ferr_cnt  = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference CRC: shift-register form straight from the frame definition.
    function automatic logic [15:0] model_crc(input logic [31:0] data, input int dw,
                                              input int cw, input logic [15:0] poly,
                                              input logic [15:0] init);
        logic [15:0] c;
        logic [15:0] mask;
        logic        fb;
        mask = 16'((32'd1 << cw) - 1);
        c    = init & mask;
        for (int i = dw - 1; i >= 0; i--) begin
            fb = c[cw-1] ^ data[i];
            c  = (c << 1) & mask;
            if (fb) c = c ^ (poly & mask);
        end
        return c;
    endfunction

    // Waits to the falling edge that follows rising edge number 'target'.
    task automatic wait_cyc(input int target);
        @(negedge clk);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain_sb(input int limit);
        for (int i = 0; i < limit && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL lb_rx_timeout: %0d frames outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Loopback scoreboard: every rx_ready pulse must match the oldest accepted frame.
    always @(negedge clk) begin
        if (rst_n && lb_ready) begin
            lb_ready_cnt++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL lb_unexpected_ready: got pulse with data 0x%0h, expected none", lb_rx_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_output("lb_rx_data", 32'(lb_rx_data), 32'(e.data));
                check_output("lb_crc_valid", 32'(lb_valid), 32'(e.valid));
                check_output("lb_latency", 32'(cyc - e.start_cyc), 32'(LAT));
            end
        end
        if (rst_n && lb_ferr) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL lb_frame_err: got 1, expected 0");
        end
        if (ex_ready) ex_ready_cnt++;
        if (ex_ferr) ex_ferr_cnt++;
        if (wd_ferr) wd_ferr_cnt++;
    end

    // One fully observed loopback frame: line bits, busy window and RX result.
    task automatic apply_stimulus(input vec_t v);
        int          s;
        logic [17:0] bits;
        logic [7:0]  line_data;
        logic [7:0]  line_crc;
        @(negedge clk);
        check_output("lb_busy_before", 32'(lb_busy), 32'd0);
        lb_data  = v.data;
        lb_inj   = v.inj;
        lb_start = 1'b1;
        s = cyc + 1;
        sb_q.push_back('{data: v.rx_data, valid: v.valid, start_cyc: s});
        @(negedge clk);
        lb_start = 1'b0;
        lb_inj   = 1'b0;
        check_output("lb_busy_after_accept", 32'(lb_busy), 32'd1);
        for (int k = 0; k < DW + CW + 2; k++) begin
            wait_cyc(s + k * CPB + CPB / 2);
            bits[k] = lb_tx;
        end
        for (int j = 0; j < DW; j++) line_data[j] = bits[1 + j];
        for (int j = 0; j < CW; j++) line_crc[CW - 1 - j] = bits[DW + 1 + j];
        check_output("lb_line_start_stop", 32'({bits[0], bits[17]}), 32'h1);
        check_output("lb_line_data", 32'(line_data), 32'(v.data ^ {7'd0, v.inj}));
        check_output("lb_line_crc", 32'(line_crc), 32'(v.line_crc));
        wait_cyc(s + FRAME - 1);
        check_output("lb_busy_last", 32'(lb_busy), 32'd1);
        @(negedge clk);
        check_output("lb_busy_end", 32'(lb_busy), 32'd0);
        drain_sb(2 * CPB);
    endtask

    // Bit-bangs one frame onto the external line; a low stop bit is kept short so its tail reads as a false start.
    task automatic send_ext(input logic [7:0] d, input logic [7:0] c, input logic stop_bit);
        logic [17:0] f;
        f[0] = 1'b0;
        for (int j = 0; j < 8; j++) f[1 + j] = d[j];
        for (int j = 0; j < 8; j++) f[9 + j] = c[7 - j];
        f[17] = stop_bit;
        @(negedge clk);
        for (int k = 0; k < 17; k++) begin
            ex_line = f[k];
            repeat (CPB) @(negedge clk);
        end
        ex_line = stop_bit;
        repeat (stop_bit ? CPB : CPB / 2 + 2) @(negedge clk);
        ex_line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          s;
        int          c0;
        logic [15:0] m16;
        logic [7:0]  crc3c;
        logic [7:0]  crcc3;
        logic [7:0]  crc5a;
        logic [15:0] wcrc;
        logic [15:0] wline;
        int          i;

        vecs[0] = '{8'hAA, 1'b0, 8'h5F, 8'hAA, 1'b1};
        vecs[1] = '{8'hCC, 1'b0, 8'h6A, 8'hCC, 1'b1};
        vecs[2] = '{8'h00, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[3] = '{8'hAA, 1'b1, 8'h5F, 8'hAB, 1'b0};
        vecs[4] = '{8'h81, 1'b0, 8'h8E, 8'h81, 1'b1};

        rst_n = 1'b0;
        lb_data = '0; lb_start = 1'b0; lb_inj = 1'b0; lb_idle_line = 1'b1;
        ex_data = '0; ex_start = 1'b0; ex_inj = 1'b0; ex_line = 1'b1;
        wd_data = '0; wd_start = 1'b0; wd_inj = 1'b0; wd_idle_line = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check_output("lb_reset_outs", 32'({lb_tx, lb_busy, lb_ready, lb_valid, lb_ferr}), 32'h10);
        check_output("lb_reset_rx_data", 32'(lb_rx_data), 32'h0);
        check_output("ex_reset_outs", 32'({ex_tx, ex_busy, ex_ready, ex_valid, ex_ferr}), 32'h10);
        check_output("wd_reset_outs", 32'({wd_tx, wd_busy, wd_ready, wd_valid, wd_ferr}), 32'h10);
        check_output("wd_reset_rx_data", 32'(wd_rx_data), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Wide configuration: 34-bit frame, line CRC, latency and check flag
        m16  = model_crc(32'h3132, WDW, WCW, 16'h1021, 16'hFFFF);
        wcrc = m16;
        wd_data  = 16'h3132;
        wd_start = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        wd_start = 1'b0;
        for (int j = 0; j < WCW; j++) begin
            wait_cyc(s + (1 + WDW + j) * CPB + CPB / 2);
            wline[WCW - 1 - j] = wd_tx;
        end
        check_output("wd_line_crc", 32'(wline), 32'(wcrc));
        i = 0;
        while (i < 200 && !wd_ready) begin
            @(negedge clk);
            i++;
        end
        if (!wd_ready) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL wd_ready_timeout: got no pulse, expected pulse");
        end else begin
            check_output("wd_latency", 32'(cyc - s), 32'(WLAT));
            check_output("wd_rx_data", 32'(wd_rx_data), 32'h3132);
            check_output("wd_crc_valid", 32'(wd_valid), 32'd1);
        end
        wait_cyc(s + WFRAME - 1);
        check_output("wd_busy_last", 32'(wd_busy), 32'd1);
        @(negedge clk);
        check_output("wd_busy_end", 32'(wd_busy), 32'd0);
        check_output("wd_no_frame_err", 32'(wd_ferr_cnt), 32'd0);

        // Table-driven loopback frames
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(vecs[k]);
        end

        // Start while busy is dropped; start held across the end of STOP is taken one cycle later
        c0 = lb_ready_cnt;
        @(negedge clk);
        lb_data  = 8'h3C;
        lb_start = 1'b1;
        s = cyc + 1;
        sb_q.push_back('{data: 8'h3C, valid: 1'b1, start_cyc: s});
        @(negedge clk);
        lb_start = 1'b0;
        wait_cyc(s + 5 * CPB);
        lb_data  = 8'h99;
        lb_start = 1'b1;
        @(negedge clk);
        lb_start = 1'b0;
        check_output("lb_busy_ignore", 32'(lb_busy), 32'd1);
        wait_cyc(s + FRAME - 2);
        lb_data  = 8'h12;
        lb_start = 1'b1;
        wait_cyc(s + FRAME);
        check_output("lb_busy_gap", 32'(lb_busy), 32'd0);
        sb_q.push_back('{data: 8'h12, valid: 1'b1, start_cyc: s + FRAME + 1});
        @(negedge clk);
        check_output("lb_busy_reaccept", 32'(lb_busy), 32'd1);
        lb_start = 1'b0;
        drain_sb(2 * FRAME);
        check_output("lb_two_frames", 32'(lb_ready_cnt - c0), 32'd2);

        // Reset in the middle of the payload
        @(negedge clk);
        lb_data  = 8'h77;
        lb_start = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        lb_start = 1'b0;
        wait_cyc(s + 4 * CPB);
        rst_n = 1'b0;
        #1;
        check_output("lb_reset_mid_outs", 32'({lb_tx, lb_busy, lb_ready, lb_valid, lb_ferr}), 32'h10);
        check_output("lb_reset_mid_rx_data", 32'(lb_rx_data), 32'h0);
        c0 = lb_ready_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (FRAME + CPB) @(negedge clk);
        check_output("lb_no_pulse_after_reset", 32'(lb_ready_cnt), 32'(c0));
        apply_stimulus(vecs[1]);

        // External line: good frame, glitch, bad CRC, framing error
        m16 = model_crc(32'h3C, DW, CW, 16'h07, 16'h0);
        crc3c = m16[7:0];
        m16 = model_crc(32'hC3, DW, CW, 16'h07, 16'h0);
        crcc3 = m16[7:0];
        m16 = model_crc(32'h5A, DW, CW, 16'h07, 16'h0);
        crc5a = m16[7:0];

        send_ext(8'h3C, crc3c, 1'b1);
        check_output("ex_good_ready", 32'(ex_ready_cnt), 32'd1);
        check_output("ex_good_data", 32'(ex_rx_data), 32'h3C);
        check_output("ex_good_valid", 32'(ex_valid), 32'd1);

        @(negedge clk);
        ex_line = 1'b0;
        @(negedge clk);
        ex_line = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_output("ex_glitch_counts", 32'({ex_ready_cnt[15:0], ex_ferr_cnt[15:0]}), 32'h0001_0000);
        check_output("ex_glitch_data", 32'({ex_rx_data, 7'd0, ex_valid}), 32'h3C01);

        send_ext(8'hC3, crcc3 ^ 8'h01, 1'b1);
        check_output("ex_badcrc_ready", 32'(ex_ready_cnt), 32'd2);
        check_output("ex_badcrc_data", 32'(ex_rx_data), 32'hC3);
        check_output("ex_badcrc_valid", 32'(ex_valid), 32'd0);

        send_ext(8'h3C, crc3c, 1'b1);
        check_output("ex_regood_valid", 32'({ex_rx_data, 7'd0, ex_valid}), 32'h3C01);

        send_ext(8'h5A, crc5a, 1'b0);
        check_output("ex_ferr_count", 32'(ex_ferr_cnt), 32'd1);
        check_output("ex_ferr_no_ready", 32'(ex_ready_cnt), 32'd3);
        check_output("ex_ferr_data_held", 32'(ex_rx_data), 32'h3C);
        check_output("ex_ferr_valid_clr", 32'(ex_valid), 32'd0);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
